// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: round-robin arbiter that merges NUM_REQ CBus masters
// (icache, dcache, uncached ports) onto one downstream CBus port.
// One master is granted per burst. While it is granted, its live request is
// forwarded downstream and the downstream response is routed back to it only.
//
// Optional feature macro: CBUS_ARB_ADDR_XLATE_EN
//   defined   : oreq.addr has the fixed MIPS kseg0/kseg1 -> physical
//               translation applied combinationally
//   undefined : oreq.addr is the granted master's address verbatim
//
// Packed bus layouts, MSB first:
//   request  (81 bits): valid, is_write, size[2:0], addr[31:0], strobe[3:0],
//                       data[31:0], len[7:0]
//   response (34 bits): ready, last, data[31:0]
// len is beats-1 (MLEN1 = 0, MLEN4 = 3, MLEN16 = 15).

module cbus_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ),
    localparam int REQ_W   = 81,
    localparam int RESP_W  = 34
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0][REQ_W-1:0]    ireqs,
    output logic [NUM_REQ-1:0][RESP_W-1:0]   iresps,
    output logic [REQ_W-1:0]                 oreq,
    input  logic [RESP_W-1:0]                oresp
);

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [7:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    localparam logic [0:0]       ST_IDLE   = 1'b0;
    localparam logic [0:0]       ST_BUSY   = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    // Fixed kseg0/kseg1 unmapped-segment translation; identity when disabled.
    function automatic logic [31:0] xlate_addr(input logic [31:0] addr);
`ifdef CBUS_ARB_ADDR_XLATE_EN
        if ((addr[31:29] == 3'b100) || (addr[31:29] == 3'b101)) begin
            xlate_addr = {3'b000, addr[28:0]};
        end else begin
            xlate_addr = addr;
        end
`else
        xlate_addr = addr;
`endif
    endfunction

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_sel;
    logic [7:0]       r_cnt;

    logic             w_found;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_next_ptr;
    cbus_req_t        w_sel_req;
    cbus_resp_t       w_resp;

    assign w_sel_req = cbus_req_t'(ireqs[r_sel]);
    assign w_resp    = cbus_resp_t'(oresp);

    // Scan valids starting at r_ptr, wrapping explicitly at NUM_REQ so a
    // non-power-of-two NUM_REQ never lands on an unused index.
    always_comb begin
        logic [IDX_W:0]   w_sum;
        logic [IDX_W-1:0] w_idx;
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (IDX_W + 1)'(i);
            if (w_sum >= NUM_REQ_W) begin
                w_sum = w_sum - NUM_REQ_W;
            end else begin
                w_sum = w_sum;
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!w_found && ireqs[w_idx][REQ_W-1]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end else begin
                w_found = w_found;
                w_pick  = w_pick;
            end
        end
    end

    // Master after the one that just finished; it becomes lowest priority.
    always_comb begin
        if (r_sel == LAST_IDX) begin
            w_next_ptr = {IDX_W{1'b0}};
        end else begin
            w_next_ptr = r_sel + IDX_W'(1);
        end
    end

    // Forward the granted master's live request and route the response back.
    always_comb begin
        cbus_req_t w_out;
        w_out  = '0;
        oreq   = '0;
        iresps = '0;
        if (r_state == ST_BUSY) begin
            w_out         = w_sel_req;
            w_out.addr    = xlate_addr(w_sel_req.addr);
            oreq          = w_out;
            iresps[r_sel] = oresp;
        end else begin
            oreq   = '0;
            iresps = '0;
        end
    end

    // Grant FSM, round-robin pointer and beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= {IDX_W{1'b0}};
            r_sel   <= {IDX_W{1'b0}};
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_BUSY;
                        r_sel   <= w_pick;
                        r_cnt   <= 8'd0;
                    end
                end
                ST_BUSY: begin
                    if (w_resp.ready) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (w_resp.last) begin
                            r_state <= ST_IDLE;
                            r_ptr   <= w_next_ptr;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    cbus_rr_arbiter_chk u_chk (
        .clk          (clk),
        .reset        (reset),
        .i_busy       (r_state == ST_BUSY),
        .i_sel_valid  (w_sel_req.valid),
        .i_resp_ready (w_resp.ready),
        .i_resp_last  (w_resp.last),
        .i_cnt        (r_cnt),
        .i_sel_len    (w_sel_req.len)
    );

endmodule

// Protocol checker for the arbiter: granted master keeps valid, no downstream
// ready while idle, and the last beat lands exactly on beat len.
module cbus_rr_arbiter_chk (
    input logic       clk,
    input logic       reset,
    input logic       i_busy,
    input logic       i_sel_valid,
    input logic       i_resp_ready,
    input logic       i_resp_last,
    input logic [7:0] i_cnt,
    input logic [7:0] i_sel_len
);

    a_sel_valid_held: assert property (@(posedge clk) disable iff (reset)
        i_busy |-> i_sel_valid);

    a_no_ready_idle: assert property (@(posedge clk) disable iff (reset)
        !i_busy |-> !i_resp_ready);

    a_last_on_len: assert property (@(posedge clk) disable iff (reset)
        (i_busy && i_resp_ready && i_resp_last) |-> (i_cnt == i_sel_len));

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed bench for cbus_rr_arbiter with hand-computed expectations.
module tb_cbus_rr_arbiter;

    localparam int NR = 4;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [7:0]  len;
    } req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } resp_t;

    localparam logic [7:0] MLEN1  = 8'd0;
    localparam logic [7:0] MLEN2  = 8'd1;
    localparam logic [7:0] MLEN4  = 8'd3;
    localparam logic [7:0] MLEN16 = 8'd15;

    logic             clk = 1'b0;
    logic             reset;
    req_t  [NR-1:0]   ireqs;
    resp_t [NR-1:0]   iresps;
    req_t             oreq;
    resp_t            oresp;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cbus_rr_arbiter #(.NUM_REQ(NR)) dut (
        .clk    (clk),
        .reset  (reset),
        .ireqs  (ireqs),
        .iresps (iresps),
        .oreq   (oreq),
        .oresp  (oresp)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef CBUS_ARB_ADDR_XLATE_EN
        if (a[31:29] == 3'b100 || a[31:29] == 3'b101) return {3'b000, a[28:0]};
        return a;
`else
        return a;
`endif
    endfunction

    function automatic logic [31:0] addr_of(input int m);
        return 32'h1000_0000 + 32'(m) * 32'h0000_0100;
    endfunction

    task automatic set_req(input int m, input bit we, input logic [31:0] a, input logic [7:0] len);
        ireqs[m]          = '0;
        ireqs[m].valid    = 1'b1;
        ireqs[m].is_write = we;
        ireqs[m].size     = 3'd2;
        ireqs[m].addr     = a;
        ireqs[m].strobe   = we ? 4'hF : 4'h0;
        ireqs[m].len      = len;
    endtask

    // Expects the arbiter idle with master m pending: checks the single idle
    // cycle, then runs 'beats' response beats and checks routing each beat.
    task automatic do_burst(input int m, input int beats, input bit we,
                            input logic [31:0] rbase, input bit drop);
        #2;
        check_value($sformatf("idle_before_m%0d", m), 64'(oreq.valid), 64'd0);
        tick;
        for (int b = 0; b < beats; b++) begin
            oresp.ready = 1'b1;
            oresp.last  = (b == beats - 1);
            oresp.data  = rbase + 32'(b);
            if (we) ireqs[m].data = 32'(b);
            #2;
            check_value($sformatf("m%0d_b%0d_valid", m, b), 64'(oreq.valid), 64'd1);
            check_value($sformatf("m%0d_b%0d_addr", m, b), 64'(oreq.addr), 64'(exp_addr(ireqs[m].addr)));
            check_value($sformatf("m%0d_b%0d_we", m, b), 64'(oreq.is_write), 64'(we));
            if (we) check_value($sformatf("m%0d_b%0d_wdata", m, b), 64'(oreq.data), 64'(b));
            for (int j = 0; j < NR; j++) begin
                if (j == m) begin
                    check_value($sformatf("m%0d_b%0d_ready", m, b), 64'(iresps[j].ready), 64'd1);
                    check_value($sformatf("m%0d_b%0d_last", m, b), 64'(iresps[j].last), 64'(b == beats - 1));
                    check_value($sformatf("m%0d_b%0d_rdata", m, b), 64'(iresps[j].data), 64'(rbase + 32'(b)));
                end else begin
                    check_value($sformatf("m%0d_b%0d_other%0d", m, b, j), 64'(iresps[j]), 64'd0);
                end
            end
            tick;
        end
        oresp = '0;
        if (drop) ireqs[m] = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] xl_addrs [3];
        xl_addrs[0] = 32'hBFC0_0000;
        xl_addrs[1] = 32'h8000_1000;
        xl_addrs[2] = 32'h0040_0000;

        reset = 1'b1;
        ireqs = '0;
        oresp = '0;
        tick;
        tick;
        #2;
        check_value("rst_oreq_zero", 64'(oreq == '0), 64'd1);
        for (int j = 0; j < NR; j++) check_value($sformatf("rst_iresp%0d", j), 64'(iresps[j]), 64'd0);
        tick;
        reset = 1'b0;

        // Single master 2 read, one beat; pointer moves to 3.
        set_req(2, 1'b0, 32'h1FC0_0000, MLEN1);
        do_burst(2, 1, 1'b0, 32'hDEAD_BEEF, 1'b1);

        // Pointer at 3 with masters 3 and 0 always valid: 3,0,3,0.
        set_req(3, 1'b0, addr_of(3), MLEN2);
        set_req(0, 1'b0, addr_of(0), MLEN2);
        do_burst(3, 2, 1'b0, 32'hA000_0000, 1'b0);
        do_burst(0, 2, 1'b0, 32'hA000_0010, 1'b0);
        do_burst(3, 2, 1'b0, 32'hA000_0020, 1'b0);
        do_burst(0, 2, 1'b0, 32'hA000_0030, 1'b1);
        ireqs[3] = '0;

        // Write burst from master 1, data 0..3 passes through per beat.
        set_req(1, 1'b1, addr_of(1), MLEN4);
        do_burst(1, 4, 1'b1, 32'h0000_0000, 1'b1);

        // Reset on beat 2 of a 16-beat read from master 2.
        set_req(2, 1'b0, addr_of(2), MLEN16);
        #2;
        check_value("mid_idle", 64'(oreq.valid), 64'd0);
        tick;
        for (int b = 0; b < 2; b++) begin
            oresp.ready = 1'b1;
            oresp.last  = 1'b0;
            oresp.data  = 32'(b);
            #2;
            check_value($sformatf("mid_b%0d_ready", b), 64'(iresps[2].ready), 64'd1);
            tick;
        end
        oresp.ready = 1'b1;
        reset       = 1'b1;
        tick;
        reset = 1'b0;
        oresp = '0;
        #2;
        check_value("mid_rst_oreq_zero", 64'(oreq == '0), 64'd1);
        for (int j = 0; j < NR; j++) check_value($sformatf("mid_rst_iresp%0d", j), 64'(iresps[j]), 64'd0);
        ireqs[2] = '0;
        tick;

        // Contention from pointer 0: masters 0,1,3 granted in that order.
        set_req(0, 1'b0, addr_of(0), MLEN4);
        set_req(1, 1'b0, addr_of(1), MLEN4);
        set_req(3, 1'b0, addr_of(3), MLEN4);
        do_burst(0, 4, 1'b0, 32'hC000_0000, 1'b1);
        do_burst(1, 4, 1'b0, 32'hC100_0000, 1'b1);
        do_burst(3, 4, 1'b0, 32'hC300_0000, 1'b1);

        // Address translation (identity when the feature is disabled).
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1'b0, xl_addrs[k], MLEN1);
            do_burst(0, 1, 1'b0, 32'h5500_0000 + 32'(k), 1'b1);
        end
`ifdef CBUS_ARB_ADDR_XLATE_EN
        check_value("xl_const_kseg1", 64'(exp_addr(xl_addrs[0])), 64'h1FC0_0000);
`else
        check_value("xl_const_kseg1", 64'(exp_addr(xl_addrs[0])), 64'hBFC0_0000);
`endif

        #2;
        check_value("final_idle", 64'(oreq.valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cbus_rr_arbiter.md
Name: cbus_rr_arbiter

Overview:
- Round-robin arbiter merging NUM_REQ cache/uncached CBus masters (icache, dcache, uncached ports) onto the single CBus port that leaves the top level as oreq/oresp.
- Grants one master per burst.
- Forwards the granted master's live request downstream and routes oresp back to that master only.
- Sits directly downstream of the cache layer, upstream of the AXI/CBus bridge.

Parameters:
- NUM_REQ, 4, number of requesting masters (2..8).
- IDX_W, $clog2(NUM_REQ), grant index width (derived; not overridable).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ireqs  input  NUM_REQ x $bits(cbus_req_t)  master requests (valid, is_write, size, addr, strobe, data, len).
- iresps  output  NUM_REQ x $bits(cbus_resp_t)  per-master responses (ready, last, data).
- oreq  output  $bits(cbus_req_t)  merged downstream request.
- oresp  input  $bits(cbus_resp_t)  downstream response.

Behaviour:
- Clock/reset: one clock (clk); reset synchronous, active-high (reset).
- Reset values: state=IDLE, ptr=0, sel=0, oreq='0, all iresps='0.
- Reset asserted mid-burst: everything returns to reset values next edge; the downstream burst is abandoned (system-level reset only).
- FSM states: IDLE, BUSY.
- IDLE:
  - oreq='0; all iresps='0.
  - Scan ireqs[i].valid in order ptr, ptr+1, ... wrapping mod NUM_REQ.
  - First valid master becomes sel; state -> BUSY next edge.
  - No valid master: stay IDLE.
- BUSY:
  - oreq = ireqs[sel] combinationally (live, so per-beat write data passes through).
  - iresps[sel] = oresp; all other iresps='0.
  - Non-granted masters hold valid and wait; they see ready=0.
- Burst end: oresp.ready && oresp.last in BUSY -> state IDLE, ptr = (sel+1) mod NUM_REQ.
- Latency:
  - Grant costs exactly one IDLE cycle: oreq.valid first rises 1 cycle after ireqs[k].valid, given the arbiter was IDLE.
  - Back-to-back bursts: one idle bubble between the last beat and the next oreq.valid.
- Simultaneous events:
  - A new valid arriving in the same cycle as the last beat is not considered until the following IDLE cycle.
  - The master that just finished gets lowest priority in the next scan.
- Protocol rules:
  - Granted master holds valid and addr/size/len/is_write stable until it sees last.
  - Deasserting valid before last is illegal.
  - Simulation assertion fires on: ireqs[sel].valid==0 in BUSY; oresp.ready in IDLE.
- Beat counter:
  - cnt, width 8, cleared on grant, incremented on each oresp.ready in BUSY.
  - Assertion: last is seen on beat cnt == ireqs[sel].len (MLEN1 -> 0, MLEN16 -> 15).
- NUM_REQ not a power of two: ptr wraps explicitly at NUM_REQ-1 -> 0, never reaching an unused index.

Optional Feature:
- Macro: CBUS_ARB_ADDR_XLATE_EN.
- Defined:
  - oreq.addr applies fixed MIPS kseg translation: addr[31:29] in {3'b100, 3'b101} (kseg0/kseg1) -> output {3'b000, addr[28:0]}.
  - Other segments pass unchanged.
  - Translation is combinational, no added latency.
- Undefined: oreq.addr = ireqs[sel].addr verbatim.

Test Plan:
- Reset -> single master: assert reset 2 cycles, then ireqs[2] valid, read, addr 0x1FC0_0000, len MLEN1. Expect oreq.valid=1 one cycle later with addr 0x1FC0_0000. Return one beat with last=1, data 0xDEADBEEF; only iresps[2].data shows it. Arbiter returns to IDLE, ptr=3.
- Contention round-robin: masters 0,1,3 all valid from cycle 0, each len MLEN4 read, ptr=0. Grant order 0,1,3; one idle cycle between bursts; each master sees exactly 4 ready beats.
- Fairness after wrap: ptr=3, masters 3 and 0 continuously valid. Grants alternate 3,0,3,0 over four bursts.
- Write burst passthrough: master 1 writes len MLEN4, strobe 4'hF, data 0x0,0x1,0x2,0x3 changing on each ready. Downstream captures 0x0..0x3 in order; iresps[1].last on 4th beat.
- Reset mid-burst: reset asserted on beat 2 of an MLEN16 read. Next cycle oreq='0, iresps all 0, state IDLE, ptr=0.
- Address translation, with CBUS_ARB_ADDR_XLATE_EN: request addr 0xBFC0_0000 -> oreq.addr 0x1FC0_0000; 0x8000_1000 -> 0x0000_1000; 0x0040_0000 unchanged. Without the macro all three pass unchanged.
